// File: rtl/frame_draw_sequencer.sv
// frame_draw_sequencer
// Per-frame render controller. On each accepted vsync edge it swaps the double
// buffer and runs the drawing layers strictly in order (index 0 first). Each
// layer gets a one-cycle start pulse and runs until its done strobe or until
// the watchdog expires. The active layer's pixel writes are muxed onto the
// single framebuffer write port, with off-screen writes dropped.
//
// Ports:
//   Clk, Reset                   system clock, asynchronous active-high reset
//   frame_clk                    vsync; a rising edge marks a frame boundary
//   layer_start                  one-hot start pulse to the current layer
//   layer_done                   per-layer done strobe (current layer, RUN only)
//   layer_wr_en/x/y/color        packed per-layer write streams
//   fb_x, fb_y, fb_color         registered framebuffer write address/data
//   fb_wr_en                     registered framebuffer write enable
//   buffer_using                 displayed buffer; drawing targets the other
//   busy                         high whenever not idle
//   frame_done                   one-cycle pulse after the last layer finishes
//   overrun                      sticky watchdog flag for the current/last frame
//   dropped_frames               saturating count of edges seen while busy
module frame_draw_sequencer #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned W          = 320,
    parameter int unsigned H          = 240,
    parameter int unsigned MAX_CYCLES = 65536
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                frame_clk,
    output logic [N_REQ-1:0]    layer_start,
    input  logic [N_REQ-1:0]    layer_done,
    input  logic [N_REQ-1:0]    layer_wr_en,
    input  logic [N_REQ*10-1:0] layer_x,
    input  logic [N_REQ*10-1:0] layer_y,
    input  logic [N_REQ*8-1:0]  layer_color,
    output logic [9:0]          fb_x,
    output logic [9:0]          fb_y,
    output logic [7:0]          fb_color,
    output logic                fb_wr_en,
    output logic                buffer_using,
    output logic                busy,
    output logic                frame_done,
    output logic                overrun,
    output logic [7:0]          dropped_frames
);
    localparam int unsigned CurW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CntW = $clog2(MAX_CYCLES) + 1;
    localparam logic [CntW-1:0] CntLimit = CntW'(MAX_CYCLES - 1);
    localparam logic [CurW-1:0] LastCur  = CurW'(N_REQ - 1);
    localparam logic [9:0]      XLimit   = 10'(W);
    localparam logic [9:0]      YLimit   = 10'(H);

    typedef enum logic [1:0] {StIdle, StStart, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CurW-1:0]  cur_q, cur_d;
    logic [CntW-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [1:0]       hist_q;
    logic             buf_q, buf_d;
    logic             ovr_q, ovr_d;
    logic [7:0]       drop_q, drop_d;
    logic             frame_edge;
    logic [N_REQ-1:0] cur_onehot;
    logic [9:0]       sel_x, sel_y;
    logic [7:0]       sel_color;
    logic             cur_done;
    logic             wr_ok;

    // Reset value 2'b11 means a frame_clk already high at reset release is not an edge.
    assign frame_edge = (hist_q == 2'b01);

    // Current-layer select: one-hot and the layer's write stream.
    always_comb begin
        cur_onehot = '0;
        sel_x      = '0;
        sel_y      = '0;
        sel_color  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (cur_q == CurW'(i)) begin
                cur_onehot[i] = 1'b1;
                sel_x         = layer_x[i*10 +: 10];
                sel_y         = layer_y[i*10 +: 10];
                sel_color     = layer_color[i*8 +: 8];
            end
        end
    end

    assign cur_done = |(layer_done & cur_onehot);
    assign wr_ok    = (state_q == StRun) && |(layer_wr_en & cur_onehot) &&
                      (sel_x < XLimit) && (sel_y < YLimit);
    assign cnt_inc  = cnt_q + CntW'(1);

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        ovr_d   = ovr_q;
        drop_d  = drop_q;

        // Edges while busy are counted and otherwise ignored; nothing is queued.
        if (frame_edge && (state_q != StIdle) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (frame_edge) begin
                    buf_d   = ~buf_q;
                    ovr_d   = 1'b0;
                    cur_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StRun;
            end
            StRun: begin
                cnt_d = cnt_inc;
                // Timeout when the counter steps onto the limit: START plus RUN
                // then spans exactly MAX_CYCLES cycles.
                if (cur_done || (cnt_inc == CntLimit)) begin
                    if (!cur_done) begin
                        ovr_d = 1'b1;
                    end
                    if (cur_q == LastCur) begin
                        state_d = StDone;
                    end else begin
                        cur_d   = cur_q + CurW'(1);
                        state_d = StStart;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= StIdle;
            cur_q    <= '0;
            cnt_q    <= '0;
            hist_q   <= 2'b11;
            buf_q    <= 1'b0;
            ovr_q    <= 1'b0;
            drop_q   <= '0;
            fb_x     <= '0;
            fb_y     <= '0;
            fb_color <= '0;
            fb_wr_en <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            cnt_q    <= cnt_d;
            hist_q   <= {hist_q[0], frame_clk};
            buf_q    <= buf_d;
            ovr_q    <= ovr_d;
            drop_q   <= drop_d;
            fb_wr_en <= wr_ok;
            if (wr_ok) begin
                fb_x     <= sel_x;
                fb_y     <= sel_y;
                fb_color <= sel_color;
            end
        end
    end

    always_comb begin
        layer_start    = (state_q == StStart) ? cur_onehot : '0;
        busy           = (state_q != StIdle);
        frame_done     = (state_q == StDone);
        buffer_using   = buf_q;
        overrun        = ovr_q;
        dropped_frames = drop_q;
    end

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// Scoreboard bench for frame_draw_sequencer. Two instances: "a" with the
// default watchdog and "b" with MAX_CYCLES = 16. Stimulus pushes expected
// events (start pulses, framebuffer writes, frame_done) with the cycle they
// must appear in; a monitor per instance pops and compares on each event.
module tb_frame_draw_sequencer;
    localparam int unsigned NR = 4;
    localparam logic [1:0] KStart = 2'd0;
    localparam logic [1:0] KWr    = 2'd1;
    localparam logic [1:0] KDone  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [27:0] data;
        logic [31:0] cyc;
    } ev_t;

    logic Clk = 1'b0;
    logic Reset;
    logic frame_clk, frame_clk_b;
    logic [NR-1:0] layer_start, layer_start_b, layer_done, layer_done_b, layer_wr_en;
    logic [NR*10-1:0] layer_x, layer_y;
    logic [NR*8-1:0] layer_color;
    logic [9:0] fb_x, fb_y, fb_x_b, fb_y_b;
    logic [7:0] fb_color, fb_color_b, dropped_frames, dropped_frames_b;
    logic fb_wr_en, fb_wr_en_b, buffer_using, buffer_using_b, busy, busy_b;
    logic frame_done, frame_done_b, overrun, overrun_b;

    int unsigned cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    ev_t q_a[$];
    ev_t q_b[$];

    frame_draw_sequencer dut_a (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .layer_start(layer_start), .layer_done(layer_done), .layer_wr_en(layer_wr_en),
        .layer_x(layer_x), .layer_y(layer_y), .layer_color(layer_color),
        .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .fb_wr_en(fb_wr_en),
        .buffer_using(buffer_using), .busy(busy), .frame_done(frame_done),
        .overrun(overrun), .dropped_frames(dropped_frames)
    );

    frame_draw_sequencer #(.MAX_CYCLES(16)) dut_b (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk_b),
        .layer_start(layer_start_b), .layer_done(layer_done_b), .layer_wr_en('0),
        .layer_x('0), .layer_y('0), .layer_color('0),
        .fb_x(fb_x_b), .fb_y(fb_y_b), .fb_color(fb_color_b), .fb_wr_en(fb_wr_en_b),
        .buffer_using(buffer_using_b), .busy(busy_b), .frame_done(frame_done_b),
        .overrun(overrun_b), .dropped_frames(dropped_frames_b)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic at(input int unsigned c);
        while (cyc < c) tick();
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input int which, input logic [1:0] kind, input logic [27:0] data,
                        input int unsigned c);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.cyc  = c;
        if (which == 0) q_a.push_back(e);
        else q_b.push_back(e);
    endtask

    task automatic observe(input int which, input logic [1:0] kind, input logic [27:0] data);
        ev_t e;
        int  n;
        n_vec++;
        n = (which == 0) ? q_a.size() : q_b.size();
        if (n == 0) begin
            n_err++;
            $display("FAIL dut%0d unexpected event: got kind=%0d data=%h cycle=%0d, required none",
                     which, kind, data, cyc);
            return;
        end
        if (which == 0) e = q_a.pop_front();
        else e = q_b.pop_front();
        if (e.kind !== kind || e.data !== data || e.cyc !== cyc) begin
            n_err++;
            $display("FAIL dut%0d event: got kind=%0d data=%h cycle=%0d, required kind=%0d data=%h cycle=%0d",
                     which, kind, data, cyc, e.kind, e.data, e.cyc);
        end
    endtask

    always @(negedge Clk) begin
        if (Reset === 1'b0) begin
            if (layer_start !== '0) observe(0, KStart, 28'(layer_start));
            if (fb_wr_en !== 1'b0) observe(0, KWr, {fb_x, fb_y, fb_color});
            if (frame_done !== 1'b0) observe(0, KDone, 28'd0);
        end
    end

    always @(negedge Clk) begin
        if (Reset === 1'b0) begin
            if (layer_start_b !== '0) observe(1, KStart, 28'(layer_start_b));
            if (fb_wr_en_b !== 1'b0) observe(1, KWr, {fb_x_b, fb_y_b, fb_color_b});
            if (frame_done_b !== 1'b0) observe(1, KDone, 28'd0);
        end
    end

    // Low for two cycles, then high; c0 is the cycle the rise is driven in.
    task automatic raise(input int which, output int unsigned c0);
        if (which == 0) frame_clk = 1'b0;
        else frame_clk_b = 1'b0;
        tick();
        tick();
        if (which == 0) frame_clk = 1'b1;
        else frame_clk_b = 1'b1;
        c0 = cyc;
    endtask

    task automatic pulse_done(input int which, input int i, input int unsigned c);
        at(c);
        if (which == 0) layer_done[i] = 1'b1;
        else layer_done_b[i] = 1'b1;
        tick();
        if (which == 0) layer_done[i] = 1'b0;
        else layer_done_b[i] = 1'b0;
    endtask

    task automatic set_wr(input int i, input logic [9:0] x, input logic [9:0] y,
                          input logic [7:0] c);
        layer_wr_en[i]       = 1'b1;
        layer_x[10*i +: 10]  = x;
        layer_y[10*i +: 10]  = y;
        layer_color[8*i +: 8] = c;
    endtask

    task automatic clr_wr();
        layer_wr_en = '0;
    endtask

    // Frame whose START for layer 0 is at s0 and every layer finishes after one RUN cycle.
    task automatic run_quick(input int which, input int unsigned s0);
        for (int i = 0; i < NR; i++) push(which, KStart, 28'(1) << i, s0 + 2 * i);
        push(which, KDone, 28'd0, s0 + 8);
        for (int i = 0; i < NR; i++) pulse_done(which, i, s0 + 2 * i + 1);
        at(s0 + 9);
    endtask

    initial begin
        int unsigned c0, c1, s0, s1, s2, s3, fd, p;
        Reset = 1'b1;
        frame_clk = 1'b1;
        frame_clk_b = 1'b0;
        layer_done = '0;
        layer_done_b = '0;
        layer_wr_en = '0;
        layer_x = '0;
        layer_y = '0;
        layer_color = '0;
        tick();
        tick();

        // Reset values
        check("rst layer_start", 32'(layer_start), 0);
        check("rst fb_x", 32'(fb_x), 0);
        check("rst fb_y", 32'(fb_y), 0);
        check("rst fb_color", 32'(fb_color), 0);
        check("rst fb_wr_en", 32'(fb_wr_en), 0);
        check("rst buffer_using", 32'(buffer_using), 0);
        check("rst busy", 32'(busy), 0);
        check("rst frame_done", 32'(frame_done), 0);
        check("rst overrun", 32'(overrun), 0);
        check("rst dropped_frames", 32'(dropped_frames), 0);
        tick();
        Reset = 1'b0;

        // frame_clk high through release: no edge
        repeat (6) tick();
        check("held high busy", 32'(busy), 0);
        check("held high buffer_using", 32'(buffer_using), 0);

        // Full frame, layers done 10/20/30/40 cycles after their starts
        raise(0, c0);
        s0 = c0 + 2;
        s1 = s0 + 11;
        s2 = s1 + 21;
        s3 = s2 + 31;
        fd = s3 + 41;
        push(0, KStart, 28'h1, s0);
        push(0, KStart, 28'h2, s1);
        push(0, KStart, 28'h4, s2);
        push(0, KStart, 28'h8, s3);
        push(0, KDone, 28'd0, fd);
        at(c0 + 1);
        check("pre-swap buffer_using", 32'(buffer_using), 0);
        at(c0 + 2);
        check("swap buffer_using", 32'(buffer_using), 1);
        check("frame busy", 32'(busy), 1);
        pulse_done(0, 0, s0 + 10);
        pulse_done(0, 1, s1 + 20);
        pulse_done(0, 2, s2 + 30);
        pulse_done(0, 3, s3 + 40);
        at(fd);
        check("busy in DONE", 32'(busy), 1);
        at(fd + 1);
        check("busy after DONE", 32'(busy), 0);
        check("no overrun", 32'(overrun), 0);

        // Write mux: qualification, off-screen masking, non-current layers
        raise(0, c0);
        s0 = c0 + 2;
        s1 = s0 + 2;
        s2 = s1 + 9;
        s3 = s2 + 2;
        push(0, KStart, 28'h1, s0);
        push(0, KStart, 28'h2, s1);
        push(0, KWr, {10'd5, 10'd7, 8'h3C}, s1 + 3);
        push(0, KWr, {10'd319, 10'd239, 8'h11}, s1 + 7);
        push(0, KStart, 28'h4, s2);
        push(0, KStart, 28'h8, s3);
        push(0, KDone, 28'd0, s3 + 2);
        pulse_done(0, 0, s0 + 1);
        at(s1);
        set_wr(1, 10'd9, 10'd9, 8'h99);
        at(s1 + 1);
        clr_wr();
        at(s1 + 2);
        set_wr(1, 10'd5, 10'd7, 8'h3C);
        set_wr(2, 10'd1, 10'd1, 8'h55);
        at(s1 + 3);
        clr_wr();
        set_wr(1, 10'd320, 10'd0, 8'hAA);
        at(s1 + 4);
        clr_wr();
        set_wr(1, 10'd0, 10'd240, 8'hBB);
        layer_done[3] = 1'b1;
        at(s1 + 5);
        clr_wr();
        layer_done[3] = 1'b0;
        set_wr(2, 10'd2, 10'd2, 8'h66);
        at(s1 + 6);
        clr_wr();
        set_wr(1, 10'd319, 10'd239, 8'h11);
        at(s1 + 7);
        clr_wr();
        pulse_done(0, 1, s1 + 8);
        pulse_done(0, 2, s2 + 1);
        pulse_done(0, 3, s3 + 1);
        at(s3 + 2);
        set_wr(3, 10'd3, 10'd3, 8'h77);
        at(s3 + 3);
        clr_wr();
        at(s3 + 4);
        check("second frame buffer_using", 32'(buffer_using), 0);
        check("idle after write frame", 32'(busy), 0);

        // Watchdog on instance b (MAX_CYCLES = 16), layer 2 never done
        raise(1, c0);
        s0 = c0 + 2;
        s1 = s0 + 2;
        s2 = s1 + 2;
        s3 = s2 + 16;
        fd = s3 + 2;
        push(1, KStart, 28'h1, s0);
        push(1, KStart, 28'h2, s1);
        push(1, KStart, 28'h4, s2);
        push(1, KStart, 28'h8, s3);
        push(1, KDone, 28'd0, fd);
        pulse_done(1, 0, s0 + 1);
        pulse_done(1, 1, s1 + 1);
        at(s3 - 1);
        check("wd overrun before expiry", 32'(overrun_b), 0);
        at(s3);
        check("wd overrun set", 32'(overrun_b), 1);
        pulse_done(1, 3, s3 + 1);
        at(fd + 3);
        check("wd overrun sticky", 32'(overrun_b), 1);
        check("wd idle", 32'(busy_b), 0);
        raise(1, c1);
        at(c1 + 1);
        check("wd overrun before next edge", 32'(overrun_b), 1);
        at(c1 + 2);
        check("wd overrun cleared", 32'(overrun_b), 0);
        run_quick(1, c1 + 2);
        check("wd overrun clean frame", 32'(overrun_b), 0);
        check("wd buffer_using", 32'(buffer_using_b), 0);
        check("wd dropped_frames", 32'(dropped_frames_b), 0);

        // Edges every 50 cycles, layers take 100 cycles each
        raise(0, c0);
        s0 = c0 + 2;
        for (int i = 0; i < NR; i++) push(0, KStart, 28'(1) << i, s0 + 100 * i);
        push(0, KDone, 28'd0, s0 + 400);
        fork
            begin
                for (int m = 0; m < 10; m++) begin
                    at(c0 + 50 * m);
                    frame_clk = 1'b1;
                    at(c0 + 50 * m + 25);
                    frame_clk = 1'b0;
                end
            end
            begin
                for (int i = 0; i < NR; i++) pulse_done(0, i, s0 + 100 * i + 99);
                run_quick(0, c0 + 452);
            end
            begin
                at(c0 + 2);
                check("drop: accepted swap", 32'(buffer_using), 1);
                at(c0 + 60);
                check("drop: first dropped", 32'(dropped_frames), 1);
                at(c0 + 451);
                check("drop: no swap while busy", 32'(buffer_using), 1);
                check("drop: count", 32'(dropped_frames), 8);
                at(c0 + 452);
                check("drop: swap when idle", 32'(buffer_using), 0);
            end
        join

        // Saturation: layer 0 hangs in RUN while 300 edges arrive
        raise(0, c0);
        push(0, KStart, 28'h1, c0 + 2);
        at(c0 + 3);
        frame_clk = 1'b0;
        check("sat: start edge not dropped", 32'(dropped_frames), 8);
        for (int k = 0; k < 100; k++) begin
            tick();
            frame_clk = 1'b1;
            tick();
            frame_clk = 1'b0;
        end
        repeat (3) tick();
        check("sat: 108 dropped", 32'(dropped_frames), 108);
        for (int k = 0; k < 200; k++) begin
            tick();
            frame_clk = 1'b1;
            tick();
            frame_clk = 1'b0;
        end
        repeat (3) tick();
        check("sat: saturated", 32'(dropped_frames), 255);
        check("sat: buffer_using", 32'(buffer_using), 1);

        // Reset in the middle of layer 2's RUN
        p  = cyc + 1;
        s1 = p + 1;
        s2 = s1 + 2;
        push(0, KStart, 28'h2, s1);
        push(0, KStart, 28'h4, s2);
        pulse_done(0, 0, p);
        pulse_done(0, 1, s1 + 1);
        at(s2 + 5);
        check("queue drained before reset", 32'(q_a.size()), 0);
        #2;
        Reset = 1'b1;
        #1;
        check("mid rst layer_start", 32'(layer_start), 0);
        check("mid rst fb_wr_en", 32'(fb_wr_en), 0);
        check("mid rst fb_x", 32'(fb_x), 0);
        check("mid rst fb_y", 32'(fb_y), 0);
        check("mid rst fb_color", 32'(fb_color), 0);
        check("mid rst buffer_using", 32'(buffer_using), 0);
        check("mid rst busy", 32'(busy), 0);
        check("mid rst frame_done", 32'(frame_done), 0);
        check("mid rst overrun", 32'(overrun), 0);
        check("mid rst dropped_frames", 32'(dropped_frames), 0);
        repeat (3) tick();
        Reset = 1'b0;
        repeat (4) tick();
        check("post rst idle", 32'(busy), 0);
        raise(0, c1);
        run_quick(0, c1 + 2);
        check("restart buffer_using", 32'(buffer_using), 1);
        check("restart idle", 32'(busy), 0);

        repeat (3) tick();
        check("queue a empty", 32'(q_a.size()), 0);
        check("queue b empty", 32'(q_b.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/frame_draw_sequencer.md
# frame_draw_sequencer

Per-frame render controller between the game logic and `framebuffer2`. On each accepted frame edge it swaps the double buffer and runs the drawing layers strictly in order. The layers are background clear, platforms, doodle and HUD. Each layer gets a start/done handshake. The sequencer owns the single framebuffer write port: it muxes the active layer's write stream onto it and masks off-screen writes. It also reports frame completion, watchdog overruns and dropped frames.

## Interface
Parameters:
- `N_REQ`, 4: number of drawing layers; index 0 is drawn first.
- `W`, 320: framebuffer width in pixels; writes with x ≥ W are suppressed.
- `H`, 240: framebuffer height in pixels; writes with y ≥ H are suppressed.
- `MAX_CYCLES`, 65536: per-layer watchdog limit, in Clk cycles.

Ports:
- `Clk`  in  1  system clock, 50 MHz.
- `Reset`  in  1  asynchronous, active-high reset.
- `frame_clk`  in  1  vertical sync (`vblank_ah`); a rising edge marks a frame boundary.
- `layer_start`  out  N_REQ  one-hot start pulse to a layer.
- `layer_done`  in  N_REQ  per-layer done strobe.
- `layer_wr_en`  in  N_REQ  per-layer pixel write strobe.
- `layer_x`  in  N_REQ*10  packed x coordinates; layer i uses bits [10i+9:10i].
- `layer_y`  in  N_REQ*10  packed y coordinates, same packing as `layer_x`.
- `layer_color`  in  N_REQ*8  packed palette indices; layer i uses bits [8i+7:8i].
- `fb_x`  out  10  framebuffer write x.
- `fb_y`  out  10  framebuffer write y.
- `fb_color`  out  8  framebuffer write data.
- `fb_wr_en`  out  1  framebuffer write enable.
- `buffer_using`  out  1  buffer currently displayed; drawing targets `~buffer_using`.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse when the last layer finishes.
- `overrun`  out  1  sticky: a watchdog fired during the current or last frame.
- `dropped_frames`  out  8  saturating count of frame edges that arrived while busy.

## Operation
- Edge detect: 2-bit history register `{hist[0], frame_clk}`, reset to 2'b11.
  - A frame edge is `hist == 2'b01`.
  - Because of the 2'b11 reset value, a `frame_clk` that is high at reset release produces no edge.
- States:
  - IDLE: `busy` = 0.
    - On a frame edge: toggle `buffer_using`, clear `overrun`, set `cur` = 0, go to START.
  - START: assert `layer_start[cur]` for exactly this cycle, clear the watchdog counter, go to RUN.
  - RUN: watchdog counter increments every cycle.
    - Leave RUN when `layer_done[cur]` = 1, or when the counter reaches MAX_CYCLES-1. The timeout case also sets `overrun`.
    - On leaving: if `cur` == N_REQ-1, go to DONE; otherwise increment `cur` and go to START.
  - DONE: pulse `frame_done`, go to IDLE.
- Frame edge while state ≠ IDLE (START, RUN or DONE):
  - `dropped_frames` increments, saturating at 255.
  - No swap; rendering continues uninterrupted.
  - The edge is not queued.
- `layer_done` is sampled only in RUN. `layer_done` of non-current layers is ignored.
- Write mux:
  - Only layer `cur` in RUN can write.
  - A write from layer `cur` is passed when `layer_wr_en[cur]` = 1, x < W and y < H.
  - Writes in START, in DONE, and from non-current layers are discarded.
- Widths:
  - `cur` is $clog2(N_REQ) bits.
  - The watchdog counter is $clog2(MAX_CYCLES)+1 bits.
  - The W/H coordinate compares are unsigned 10-bit.

## Timing
- Reset (asynchronous) values: state IDLE; `cur` = 0.
  - All outputs 0: `layer_start`, `fb_x`, `fb_y`, `fb_color`, `fb_wr_en`, `buffer_using`, `busy`, `frame_done`, `overrun`, `dropped_frames`.
  - Reset asserted mid-frame aborts immediately; there is no `frame_done`.
- Frame start:
  - `frame_clk` rises before Clk edge k; `hist` = 01 after edge k.
  - At edge k+1: `buffer_using` toggles and the state becomes START (`layer_start[0]` high).
  - At edge k+2: RUN.
- Layer handoff:
  - `layer_done[i]` high before edge n: START for layer i+1 after edge n, then RUN after edge n+1.
  - Minimum time per layer is 2 cycles.
- Write path: `fb_*` are registered, so a qualified write appears one cycle after it is sampled.
- `frame_done` is high for the single cycle after the last RUN exit.
- Watchdog: RUN with no done exits exactly MAX_CYCLES cycles after the START cycle.

## Test plan
- Reset with `frame_clk` held at 1, release, hold → no START and `buffer_using` = 0. One 0→1 edge → `buffer_using` = 1 two cycles later; `layer_start` = 4'b0001 for one cycle.
- Layers raise `layer_done` 10, 20, 30 and 40 cycles after their starts → starts 0001, 0010, 0100, 1000 in order; a single `frame_done` pulse; `overrun` = 0; `busy` low again after DONE.
- Layer 1 writes (5,7,8'h3C), then (320,0,x), then (0,240,x); layer 2 writes during layer 1's RUN → exactly one `fb_wr_en` pulse, with `fb_x` = 5, `fb_y` = 7, `fb_color` = 8'h3C one cycle later.
- MAX_CYCLES = 16; layer 2 never asserts done → layer 3 starts 16 cycles after layer 2's START; `overrun` = 1; it clears at the next accepted frame edge.
- Frame edges arrive every 50 cycles while each layer takes 100 cycles → `dropped_frames` counts every edge that lands in START/RUN/DONE, and `buffer_using` toggles only on edges accepted in IDLE. Force 300 dropped edges → `dropped_frames` = 255.
- Assert `Reset` in the middle of layer 2's RUN → all outputs are 0 immediately with no `frame_done`; the next frame edge restarts from layer 0.
